// File: rtl/bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// bus_rr_arbiter
//
// Purpose:
//   Arbitrates NUM_MASTERS request ports onto one shared bus master port.
//   Winners are picked round-robin. The granted request is latched into
//   registered bus outputs and held until the slave acks. When TIMEOUT is
//   non-zero, a transaction the slave never acks is aborted. The granted
//   master then sees an ack pulse together with an error pulse.
//
// Parameters:
//   NUM_MASTERS  number of requesting ports (>= 1); port 0 is instruction fetch
//   XLEN         address/data width; byte enables are XLEN/8 wide
//   TIMEOUT      BUSY cycles without i_ack before abort; 0 disables the abort
//
// Ports:
//   i_clk, i_rst    clock (rising edge), asynchronous active-low reset
//   i_m_req         per-master request, held with stable fields until ack
//   i_m_wr_en       per-master write (1) / read (0)
//   i_m_addr        packed addresses, master k at [k*XLEN +: XLEN]
//   i_m_wr_data     packed write data, same packing as i_m_addr
//   i_m_byte_en     packed byte enables, master k at [k*XLEN/8 +: XLEN/8]
//   o_m_ack         one-cycle completion pulse to the granted master
//   o_m_err         one-cycle timeout pulse, coincident with o_m_ack
//   o_m_rd_data     shared read data, non-zero only while an ack is shown
//   i_ack           bus slave completion
//   i_rd_data       bus read data
//   o_bus_en        bus strobe
//   o_wr_en         bus write qualifier
//   o_addr          bus address
//   o_wr_data       bus write data
//   o_byte_en       bus byte enables
// ---------------------------------------------------------------------------
module bus_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int XLEN        = 32,
  parameter int TIMEOUT     = 0
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [NUM_MASTERS-1:0]          i_m_req,
  input  logic [NUM_MASTERS-1:0]          i_m_wr_en,
  input  logic [NUM_MASTERS*XLEN-1:0]     i_m_addr,
  input  logic [NUM_MASTERS*XLEN-1:0]     i_m_wr_data,
  input  logic [NUM_MASTERS*XLEN/8-1:0]   i_m_byte_en,
  output logic [NUM_MASTERS-1:0]          o_m_ack,
  output logic [NUM_MASTERS-1:0]          o_m_err,
  output logic [XLEN-1:0]                 o_m_rd_data,
  input  logic                            i_ack,
  input  logic [XLEN-1:0]                 i_rd_data,
  output logic                            o_bus_en,
  output logic                            o_wr_en,
  output logic [XLEN-1:0]                 o_addr,
  output logic [XLEN-1:0]                 o_wr_data,
  output logic [XLEN/8-1:0]               o_byte_en
);

  localparam int BE_W    = XLEN / 8;
  localparam int IDX_W   = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state;
  // The round-robin pointer and the grant index are the same register.
  // The pointer is always moved to the winner at grant time, so while in
  // BUSY it names the master being served. While in IDLE it names the
  // master that was served last.
  logic [IDX_W-1:0] last_grant;
  logic [CNT_W-1:0] cnt;

  int               cand;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             win_wr;
  logic [XLEN-1:0]  win_addr;
  logic [XLEN-1:0]  win_wdata;
  logic [BE_W-1:0]  win_be;

  logic             timeout_hit;

  // Round-robin search starting one past the last grant and wrapping.
  // The first requester found wins. Its request fields are muxed out here,
  // so that IDLE only has to register them.
  always_comb begin
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    win_be    = '0;
    for (int off = 1; off <= NUM_MASTERS; off++) begin
      cand = (int'(last_grant) + off) % NUM_MASTERS;
      if (!win_found && i_m_req[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
        win_wr    = i_m_wr_en[IDX_W'(cand)];
        win_addr  = i_m_addr[cand*XLEN +: XLEN];
        win_wdata = i_m_wr_data[cand*XLEN +: XLEN];
        win_be    = i_m_byte_en[cand*BE_W +: BE_W];
      end
    end
  end

  // The counter equals (BUSY cycle number - 1). Reaching TO_LAST therefore
  // means this is BUSY cycle TIMEOUT. That is the last cycle the slave gets
  // before the abort.
  assign timeout_hit = (TIMEOUT > 0) && (state == BUSY) && (cnt == CNT_W'(TO_LAST));

  // Completion signalling to the masters is combinational. This keeps the
  // ack in the same cycle as the slave's i_ack. An ack from the slave takes
  // priority over a timeout landing in the same cycle. Read data is forced
  // to zero whenever no ack is being shown.
  always_comb begin
    o_m_ack     = '0;
    o_m_err     = '0;
    o_m_rd_data = '0;
    if (state == BUSY) begin
      if (i_ack) begin
        o_m_ack[last_grant] = 1'b1;
        o_m_rd_data         = i_rd_data;
      end else if (timeout_hit) begin
        o_m_ack[last_grant] = 1'b1;
        o_m_err[last_grant] = 1'b1;
      end
    end
  end

  // Main FSM with registered bus outputs.
  // IDLE: registers the round-robin winner onto the bus, or drives the bus
  //       to zero when nobody is requesting.
  // BUSY: holds the bus steady until ack or timeout, then drops back to
  //       IDLE. This costs at least one idle cycle between transactions.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_MASTERS - 1);
      cnt        <= '0;
      o_bus_en   <= 1'b0;
      o_wr_en    <= 1'b0;
      o_addr     <= '0;
      o_wr_data  <= '0;
      o_byte_en  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state      <= BUSY;
            last_grant <= win_idx;
            cnt        <= '0;
            o_bus_en   <= 1'b1;
            o_wr_en    <= win_wr;
            o_addr     <= win_addr;
            o_wr_data  <= win_wdata;
            o_byte_en  <= win_be;
          end else begin
            o_bus_en   <= 1'b0;
            o_wr_en    <= 1'b0;
            o_addr     <= '0;
            o_wr_data  <= '0;
            o_byte_en  <= '0;
          end
        end
        BUSY: begin
          if (i_ack || timeout_hit) begin
            state     <= IDLE;
            cnt       <= '0;
            o_bus_en  <= 1'b0;
            o_wr_en   <= 1'b0;
            o_addr    <= '0;
            o_wr_data <= '0;
            o_byte_en <= '0;
          end else if (TIMEOUT > 0) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // At most one master is ever completed at a time. An error pulse is
  // never shown without its ack.
  a_ack_onehot : assert property (@(posedge i_clk) disable iff (!i_rst)
    $onehot0(o_m_ack));
  a_err_with_ack : assert property (@(posedge i_clk) disable iff (!i_rst)
    ((o_m_err & ~o_m_ack) == '0));

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_rr_arbiter
//
// Purpose:
//   Self-checking bench for bus_rr_arbiter with NUM_MASTERS=4, TIMEOUT=8.
//   The driver models the masters and the slave. For every transaction it
//   issues, it pushes the expected completion into a scoreboard queue. The
//   monitor runs on the falling edge. It compares the bus outputs with the
//   head of the queue. Whenever an ack appears, it pops the head and
//   compares the ack, error, read data and completion cycle.
//
//   The reference model of arbitration is deliberately high level. The
//   winner is the pending master whose distance after the last winner,
//   taken modulo N, is smallest.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_bus_rr_arbiter;

  localparam int N    = 4;
  localparam int XLEN = 32;
  localparam int TO   = 8;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b0;
  logic [N-1:0]         i_m_req;
  logic [N-1:0]         i_m_wr_en;
  logic [N*XLEN-1:0]    i_m_addr;
  logic [N*XLEN-1:0]    i_m_wr_data;
  logic [N*XLEN/8-1:0]  i_m_byte_en;
  logic [N-1:0]         o_m_ack;
  logic [N-1:0]         o_m_err;
  logic [XLEN-1:0]      o_m_rd_data;
  logic                 i_ack;
  logic [XLEN-1:0]      i_rd_data;
  logic                 o_bus_en;
  logic                 o_wr_en;
  logic [XLEN-1:0]      o_addr;
  logic [XLEN-1:0]      o_wr_data;
  logic [XLEN/8-1:0]    o_byte_en;

  bus_rr_arbiter #(.NUM_MASTERS(N), .XLEN(XLEN), .TIMEOUT(TO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_m_req     (i_m_req),
    .i_m_wr_en   (i_m_wr_en),
    .i_m_addr    (i_m_addr),
    .i_m_wr_data (i_m_wr_data),
    .i_m_byte_en (i_m_byte_en),
    .o_m_ack     (o_m_ack),
    .o_m_err     (o_m_err),
    .o_m_rd_data (o_m_rd_data),
    .i_ack       (i_ack),
    .i_rd_data   (i_rd_data),
    .o_bus_en    (o_bus_en),
    .o_wr_en     (o_wr_en),
    .o_addr      (o_addr),
    .o_wr_data   (o_wr_data),
    .o_byte_en   (o_byte_en)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          master;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rd;
    bit          err;
    int          start;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  bit          skip_mon = 1'b0;

  bit          pending [N];
  bit          p_wr    [N];
  logic [31:0] p_addr  [N];
  logic [31:0] p_wdata [N];
  logic [3:0]  p_be    [N];
  int          last = N - 1;

  // Free-running cycle count. Each scoreboard entry records the cycles in
  // which the bus and the ack are expected.
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus checks against the head of the scoreboard run first. Completion
  // checks follow: pop on any ack, or flag an ack that is overdue.
  always @(negedge i_clk) begin
    if (!skip_mon) begin
      if (sb.size() > 0 && cyc >= sb[0].start) begin
        checkOutput("bus_en",    32'(o_bus_en), 32'd1);
        checkOutput("bus_addr",  o_addr, sb[0].addr);
        checkOutput("bus_wr_en", 32'(o_wr_en), 32'(sb[0].wr));
        checkOutput("bus_be",    32'(o_byte_en), 32'(sb[0].be));
        if (sb[0].wr) checkOutput("bus_wdata", o_wr_data, sb[0].wdata);
      end else begin
        checkOutput("bus_idle", 32'(o_bus_en), 32'd0);
      end
    end
    if (o_m_ack != '0) begin
      if (sb.size() == 0) begin
        checkOutput("stray_ack", 32'(o_m_ack), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        checkOutput("ack_vec", 32'(o_m_ack), 32'(1) << mon_e.master);
        checkOutput("err_vec", 32'(o_m_err), mon_e.err ? (32'(1) << mon_e.master) : 32'd0);
        checkOutput("ack_cycle", 32'(cyc), 32'(mon_e.due));
        if (mon_e.err)     checkOutput("rd_on_timeout", o_m_rd_data, 32'd0);
        else if (!mon_e.wr) checkOutput("rd_data", o_m_rd_data, mon_e.rd);
      end
    end else begin
      checkOutput("err_idle", 32'(o_m_err), 32'd0);
      checkOutput("rd_idle",  o_m_rd_data, 32'd0);
      if (sb.size() > 0 && cyc >= sb[0].due) begin
        checkOutput("ack_missing", 32'(o_m_ack), 32'(1) << sb[0].master);
        void'(sb.pop_front());
      end
    end
  end

  task automatic driveReqs();
    for (int k = 0; k < N; k++) begin
      i_m_req[k]               = pending[k];
      i_m_wr_en[k]             = p_wr[k];
      i_m_addr[k*32 +: 32]     = p_addr[k];
      i_m_wr_data[k*32 +: 32]  = p_wdata[k];
      i_m_byte_en[k*4 +: 4]    = p_be[k];
    end
  endtask

  task automatic addRequest(input int k, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
    if (!pending[k]) begin
      pending[k] = 1'b1;
      p_wr[k]    = wr;
      p_addr[k]  = addr;
      p_wdata[k] = wdata;
      p_be[k]    = be;
    end
  endtask

  // Reference arbitration: the pending master closest after the last winner.
  function automatic int pickWinner();
    int best = -1;
    int bd   = N;
    for (int k = 0; k < N; k++) begin
      if (pending[k]) begin
        int d = (k - last - 1 + 2 * N) % N;
        if (d < bd) begin
          bd   = d;
          best = k;
        end
      end
    end
    return best;
  endfunction

  // Drive one transaction from an IDLE cycle (called at posedge+1).
  // ack_cycle is the 1-based BUSY cycle in which the slave acks. A value
  // above TO means the slave stays silent and the arbiter must time out.
  // The task returns at posedge+1 of the IDLE cycle after completion.
  task automatic applyStimulus(input int ack_cycle, input logic [31:0] rd);
    exp_t e;
    int   w;
    int   endc;
    driveReqs();
    w = pickWinner();
    if (w < 0) begin
      $display("[TB] no pending request, transaction skipped");
      return;
    end
    endc    = (ack_cycle > TO) ? TO : ack_cycle;
    e.master = w;
    e.wr     = p_wr[w];
    e.addr   = p_addr[w];
    e.wdata  = p_wdata[w];
    e.be     = p_be[w];
    e.rd     = rd;
    e.err    = (ack_cycle > TO);
    e.start  = cyc + 1;
    e.due    = cyc + endc;
    sb.push_back(e);
    last = w;
    @(posedge i_clk); #1;
    for (int j = 1; j <= endc; j++) begin
      if (j == ack_cycle) begin
        i_ack     = 1'b1;
        i_rd_data = rd;
      end else begin
        i_ack     = 1'b0;
        i_rd_data = $urandom;
      end
      @(posedge i_clk); #1;
    end
    i_ack      = 1'b0;
    i_rd_data  = $urandom;
    pending[w] = 1'b0;
    driveReqs();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int any;
    for (int k = 0; k < N; k++) begin
      pending[k] = 1'b0;
      p_wr[k]    = 1'b0;
      p_addr[k]  = '0;
      p_wdata[k] = '0;
      p_be[k]    = '0;
    end
    i_ack     = 1'b0;
    i_rd_data = 32'h5a5a_5a5a;
    driveReqs();

    // Reset state.
    #2;
    checkOutput("rst_bus_en", 32'(o_bus_en), 32'd0);
    checkOutput("rst_wr_en",  32'(o_wr_en), 32'd0);
    checkOutput("rst_addr",   o_addr, 32'd0);
    checkOutput("rst_wdata",  o_wr_data, 32'd0);
    checkOutput("rst_be",     32'(o_byte_en), 32'd0);
    checkOutput("rst_ack",    32'(o_m_ack), 32'd0);
    checkOutput("rst_err",    32'(o_m_err), 32'd0);
    checkOutput("rst_rd",     o_m_rd_data, 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b1;
    @(posedge i_clk); #1;

    $display("[TB] single read by master 1");
    addRequest(1, 1'b0, 32'h100, 32'h0, 4'hf);
    applyStimulus(3, 32'hdeadbeef);

    $display("[TB] write pass-through by master 0");
    addRequest(0, 1'b1, 32'h2000, 32'h12345678, 4'b0011);
    applyStimulus(2, $urandom);

    $display("[TB] timeout with silent slave");
    addRequest(2, 1'b0, 32'h3000, 32'h0, 4'hf);
    applyStimulus(20, $urandom);

    $display("[TB] ack in the timeout cycle");
    addRequest(3, 1'b0, 32'h4000, 32'h0, 4'hf);
    applyStimulus(TO, 32'hcafef00d);

    addRequest(1, 1'b0, 32'h5000, 32'h0, 4'h1);
    applyStimulus(1, 32'h11112222);

    $display("[TB] stray ack in IDLE");
    i_ack     = 1'b1;
    i_rd_data = 32'hbadc0de0;
    @(posedge i_clk); #1;
    i_ack     = 1'b0;
    addRequest(0, 1'b0, 32'h6000, 32'h0, 4'hf);
    addRequest(2, 1'b0, 32'h6004, 32'h0, 4'hf);
    applyStimulus(1, 32'h33334444);
    applyStimulus(1, 32'h55556666);

    $display("[TB] reset in the middle of BUSY");
    addRequest(2, 1'b1, 32'h7000, 32'habcd0123, 4'hf);
    addRequest(3, 1'b0, 32'h7004, 32'h0, 4'hf);
    skip_mon = 1'b1;
    driveReqs();
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    #2;
    i_rst = 1'b0;
    i_ack = 1'b1;
    #1;
    checkOutput("mid_rst_bus_en", 32'(o_bus_en), 32'd0);
    checkOutput("mid_rst_wr_en",  32'(o_wr_en), 32'd0);
    checkOutput("mid_rst_addr",   o_addr, 32'd0);
    checkOutput("mid_rst_wdata",  o_wr_data, 32'd0);
    checkOutput("mid_rst_be",     32'(o_byte_en), 32'd0);
    checkOutput("mid_rst_ack",    32'(o_m_ack), 32'd0);
    checkOutput("mid_rst_err",    32'(o_m_err), 32'd0);
    checkOutput("mid_rst_rd",     o_m_rd_data, 32'd0);
    for (int k = 0; k < N; k++) pending[k] = 1'b0;
    driveReqs();
    i_ack = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    i_rst    = 1'b1;
    last     = N - 1;
    skip_mon = 1'b0;
    addRequest(0, 1'b0, 32'h8000, 32'h0, 4'hf);
    addRequest(1, 1'b0, 32'h8004, 32'h0, 4'hf);
    applyStimulus(1, 32'h77778888);
    applyStimulus(2, 32'h9999aaaa);

    $display("[TB] fairness with all masters re-requesting");
    for (int r = 0; r < 12; r++) begin
      for (int k = 0; k < N; k++) addRequest(k, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
      applyStimulus(1, $urandom);
    end

    $display("[TB] randomized traffic");
    for (int r = 0; r < 60; r++) begin
      any = 0;
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 1) == 1) addRequest(k, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
        if (pending[k]) any = 1;
      end
      if (any == 0) addRequest($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom));
      applyStimulus($urandom_range(1, 10), $urandom);
    end

    // Drain whatever requests are still pending.
    for (int r = 0; r < N; r++) begin
      if (pickWinner() >= 0) applyStimulus(1, $urandom);
    end

    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Parametrised N-master to single-bus-master arbiter for multi-hart and multi-port tops. It generalises the fixed two-port (instruction/data) bus bridge to NUM_MASTERS request ports, with round-robin fairness and an optional transaction timeout with error reporting. It sits between the per-hart memory ports and the shared `BUS_M` master interface.

## Interface
- NUM_MASTERS, 2, number of requesting ports (≥1); index 0 is instruction fetch by convention.
- XLEN, 32, address/data width; byte-enable width is XLEN/8.
- TIMEOUT, 0, cycles in BUSY without i_ack before abort; 0 disables the timeout.
- i_clk  in  1  clock, all state on rising edge.
- i_rst  in  1  reset, asynchronous, active-low.
- i_m_req  in  NUM_MASTERS  per-master request; held high with fields stable until that master's o_m_ack.
- i_m_wr_en  in  NUM_MASTERS  per-master write (1) / read (0).
- i_m_addr  in  NUM_MASTERS*XLEN  packed addresses, master k at [k*XLEN +: XLEN].
- i_m_wr_data  in  NUM_MASTERS*XLEN  packed write data.
- i_m_byte_en  in  NUM_MASTERS*XLEN/8  packed byte enables.
- o_m_ack  out  NUM_MASTERS  one-cycle completion pulse to the granted master.
- o_m_err  out  NUM_MASTERS  one-cycle timeout pulse, coincident with o_m_ack.
- o_m_rd_data  out  XLEN  shared read data, valid only when some o_m_ack bit is high.
- i_ack  in  1  bus slave completion.
- i_rd_data  in  XLEN  bus read data.
- o_bus_en, o_wr_en  out  1  bus strobe / write qualifier.
- o_addr, o_wr_data  out  XLEN  bus address / write data.
- o_byte_en  out  XLEN/8  bus byte enables.

## Operation
- FSM states: IDLE, BUSY.
- IDLE: if any i_m_req bit is set, select the winner by round-robin, latch its wr_en/addr/wr_data/byte_en into the output registers, store grant index g, set o_bus_en=1, and go to BUSY. Otherwise hold all bus outputs at 0.
- Round-robin: pointer p holds the last granted index. Search order is p+1 … p+NUM_MASTERS, modulo NUM_MASTERS. p is updated to g on grant. Reset value of p is NUM_MASTERS-1, so master 0 wins first.
- BUSY: bus outputs are held constant. On i_ack:
  - o_m_ack[g]=1 combinationally;
  - o_m_rd_data=i_rd_data combinationally (0 on writes is not required; data is ignored);
  - return to IDLE at the edge, with o_bus_en=0 the next cycle.
- Timeout (TIMEOUT>0): a counter of width $clog2(TIMEOUT+1) clears on entry to BUSY and increments each BUSY cycle without i_ack. When it reaches TIMEOUT-1 without i_ack:
  - o_m_ack[g]=1 and o_m_err[g]=1;
  - o_m_rd_data=0;
  - return to IDLE.
- Simultaneous i_ack and timeout: ack wins, so o_m_err=0.
- i_ack while in IDLE is ignored; no o_m_ack is produced.
- o_m_rd_data=0 whenever no o_m_ack bit is high.
- A master deasserts i_m_req in the cycle after its ack, or it is re-arbitrated. A request dropped before ack is a protocol violation, but the transaction still completes on the bus.
- NUM_MASTERS=1: the arbiter degenerates to a registered pass-through with the same timing.

## Timing
- Reset (i_rst=0, immediate): state IDLE, p=NUM_MASTERS-1, counter 0, o_bus_en=o_wr_en=0, o_addr=o_wr_data=0, o_byte_en=0. o_m_ack, o_m_err and o_m_rd_data are all 0.
- Reset mid-transaction aborts without ack. The first request after reset release is arbitrated normally.
- Request sampled in IDLE at edge t → o_bus_en=1 from cycle t+1.
- Earliest i_ack is in cycle t+1 → o_m_ack in the same cycle (zero added completion latency).
- Minimum 1 IDLE cycle between transactions. Peak throughput is 1 transaction per 2 cycles with single-cycle slaves.
- Timeout abort occurs in BUSY cycle TIMEOUT (1-based) when no ack has been seen.

## Test plan
- Single request: NUM_MASTERS=2, master 1 reads addr 0x100, slave acks 2 cycles after o_bus_en with 0xDEADBEEF → o_addr=0x100, o_wr_en=0 throughout BUSY; o_m_ack=2'b10 for exactly 1 cycle with o_m_rd_data=0xDEADBEEF.
- Fairness: NUM_MASTERS=4, all masters requesting continuously (re-requesting after each ack), single-cycle acks → grant order 0,1,2,3,0,1… with no master granted twice before all others are granted once.
- Write pass-through: master 0 writes 0x12345678 to 0x2000 with byte_en 4'b0011 → bus shows those exact values from t+1 until ack; o_wr_en=1.
- Timeout: TIMEOUT=8, i_ack never asserted → o_m_ack[g]=o_m_err[g]=1 in BUSY cycle 8, o_m_rd_data=0, o_bus_en=0 next cycle. Variant: ack arrives in cycle 8 → o_m_err stays 0.
- Reset mid-BUSY: assert i_rst=0 two cycles after grant → all outputs 0 asynchronously, no o_m_ack; after release, master 0 wins a 0/1 tie.
- Stray ack: pulse i_ack in IDLE → no o_m_ack, state remains IDLE, p unchanged.
